// File: rtl/clk_div_meter.sv
// ============================================================================
// Module   : clk_div_meter
// Purpose  : Measures the period and high-phase length of a divided clock
//            (asynchronous to clk) in units of clk cycles, compares them with
//            an expected division ratio and a 50% duty target, tracks lock on
//            a stable period and flags a missing clock with a timeout.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   en            in   measurement enable; low returns the meter to IDLE
//   clk_div_in    in   divided clock under test (asynchronous)
//   num_div_exp   in   expected period in clk cycles
//   period        out  last measured period
//   high_time     out  last measured high-phase length
//   meas_vld      out  one-cycle pulse when period/high_time update
//   locked        out  LOCK_CNT consecutive equal periods seen
//   err_mismatch  out  pulse with meas_vld when period != num_div_exp
//   err_duty      out  pulse with meas_vld when 2*high_time != period
//   timeout       out  pulse when the period counter saturates
// ============================================================================
`default_nettype none

module clk_div_meter #(
  parameter int WIDTH_NUM_DIV = 4,
  parameter int LOCK_CNT      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clk_div_in,
  input  logic [WIDTH_NUM_DIV-1:0] num_div_exp,
  output logic [WIDTH_NUM_DIV+1:0] period,
  output logic [WIDTH_NUM_DIV+1:0] high_time,
  output logic                     meas_vld,
  output logic                     locked,
  output logic                     err_mismatch,
  output logic                     err_duty,
  output logic                     timeout
);

  localparam int            CW      = WIDTH_NUM_DIV + 2;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_PRE = {{(CW-1){1'b1}}, 1'b0};
  localparam logic [2:0]    LOCK_T  = 3'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t          state, state_nxt;

  logic            s1, s2, s3;
  logic            rise, fall;

  logic [CW-1:0]   cnt;          // period counter
  logic [CW-1:0]   hcnt;         // running high-phase counter
  logic [CW-1:0]   hlat;         // high-phase length latched at the fall
  logic [CW-1:0]   prev_period;
  logic [2:0]      lock_cnt;

  logic            do_clear;
  logic            do_reload;
  logic            do_meas;
  logic            do_timeout;

  // --------------------------------------------------------------------------
  // Synchronizer and edge detect. The fixed 2-cycle latency applies equally to
  // every edge, so measured intervals are exact.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_div_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    do_clear   = 1'b0;
    do_reload  = 1'b0;
    do_meas    = 1'b0;
    do_timeout = 1'b0;
    // en has priority over everything, including a coincident rise
    if (!en) begin
      state_nxt = IDLE;
      do_clear  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (rise) begin
            do_reload = 1'b1;
            state_nxt = MEASURE;
          end else if (cnt == CNT_PRE) begin
            do_timeout = 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            do_reload = 1'b1;
            do_meas   = 1'b1;
          end else if (cnt == CNT_PRE) begin
            do_timeout = 1'b1;
            state_nxt  = WAIT_EDGE;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Counters. The reload value is 1 because the rise cycle itself is the first
  // cycle of the new period (and the first high cycle).
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      hcnt <= '0;
      hlat <= '0;
    end else if (do_clear) begin
      cnt  <= '0;
      hcnt <= '0;
      hlat <= '0;
    end else if (do_reload) begin
      cnt  <= {{(CW-1){1'b0}}, 1'b1};
      hcnt <= {{(CW-1){1'b0}}, 1'b1};
    end else if (state != IDLE) begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      if (state == MEASURE) begin
        if (s2 && (hcnt != CNT_MAX)) begin
          hcnt <= hcnt + 1'b1;
        end
        if (fall) begin
          hlat <= hcnt;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Measurement outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period    <= '0;
      high_time <= '0;
      meas_vld  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      meas_vld <= do_meas;
      timeout  <= do_timeout;
      if (do_meas) begin
        period    <= cnt;
        high_time <= hlat;
      end
    end
  end

  // Compared in the meas_vld cycle so a changing num_div_exp is sampled there.
  assign err_mismatch = meas_vld & (period != {2'b00, num_div_exp});
  assign err_duty     = meas_vld & ({high_time, 1'b0} != {1'b0, period});

  // --------------------------------------------------------------------------
  // Lock tracking
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt    <= '0;
      prev_period <= '0;
    end else if (do_clear) begin
      lock_cnt    <= '0;
      prev_period <= '0;
    end else if (do_timeout) begin
      lock_cnt <= '0;
    end else if (meas_vld) begin
      prev_period <= period;
      if (period == prev_period) begin
        if (lock_cnt != LOCK_T) begin
          lock_cnt <= lock_cnt + 3'd1;
        end
      end else begin
        lock_cnt <= 3'd1;
      end
    end
  end

  // A mismatch or timeout pulse drops lock in the very cycle it is flagged.
  assign locked = (lock_cnt == LOCK_T) & ~err_mismatch & ~timeout;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_meter.sv
// ============================================================================
// Module   : tb_clk_div_meter
// Purpose  : Self-checking bench for clk_div_meter. Each generated period of
//            clk_div_in carries its hand-computed expected measurement, which
//            is queued when the following rise is driven; a monitor pops and
//            compares on every meas_vld or timeout pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_div_meter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clk_div_in;
  logic [3:0] num_div_exp;
  logic [5:0] period;
  logic [5:0] high_time;
  logic       meas_vld;
  logic       locked;
  logic       err_mismatch;
  logic       err_duty;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_to;
    logic [5:0] per;
    logic [5:0] hi;
    logic       mm;
    logic       du;
    logic       lk;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  bit   pend_v = 1'b0;

  clk_div_meter #(
    .WIDTH_NUM_DIV (4),
    .LOCK_CNT      (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clk_div_in   (clk_div_in),
    .num_div_exp  (num_div_exp),
    .period       (period),
    .high_time    (high_time),
    .meas_vld     (meas_vld),
    .locked       (locked),
    .err_mismatch (err_mismatch),
    .err_duty     (err_duty),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every output event must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && (meas_vld || timeout)) begin
      if (q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.is_to) begin
          chk("to_timeout", int'(timeout), 1);
          chk("to_meas_vld", int'(meas_vld), 0);
          chk("to_locked", int'(locked), 0);
        end else begin
          chk("meas_vld", int'(meas_vld), 1);
          chk("meas_timeout", int'(timeout), 0);
          chk("period", int'(period), int'(e.per));
          chk("high_time", int'(high_time), int'(e.hi));
          chk("err_mismatch", int'(err_mismatch), int'(e.mm));
          chk("err_duty", int'(err_duty), int'(e.du));
          chk("locked", int'(locked), int'(e.lk));
        end
      end
    end
  end

  // One period of clk_div_in: h cycles high, l cycles low. Starts and ends on a
  // falling clk edge. The rise completes the previous period, so that period's
  // expectation is queued here; this period's expectation becomes pending.
  task automatic run(input int h, input int l, input int ep, input int eh,
                     input bit emm, input bit edu, input bit elk);
    clk_div_in = 1'b1;
    if (pend_v) q.push_back(pend);
    pend   = '{1'b0, 6'(ep), 6'(eh), emm, edu, elk};
    pend_v = 1'b1;
    repeat (h) @(negedge clk);
    clk_div_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n;
    n = 0;
    while (q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    clk_div_in  = 1'b0;
    num_div_exp = 4'd4;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_period", int'(period), 0);
    chk("rst_high_time", int'(high_time), 0);
    chk("rst_meas_vld", int'(meas_vld), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_errs", int'({err_mismatch, err_duty, timeout}), 0);

    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);

    // Divide-by-4, expected 4: lock after the third measurement
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 1);
    run(2, 2, 4, 2, 0, 0, 1);
    run(2, 2, 4, 2, 0, 0, 1);
    chk("locked_div4", int'(locked), 1);

    // Switch to divide-by-8: one mismatch, then relock with expected 8
    run(4, 4, 8, 4, 1, 0, 0);
    run(4, 4, 8, 4, 0, 0, 0);
    num_div_exp = 4'd8;
    run(4, 4, 8, 4, 0, 0, 0);
    run(4, 4, 8, 4, 0, 0, 1);
    run(4, 4, 8, 4, 0, 0, 1);

    // 3 high / 5 low: duty error every measurement, period still matches
    run(3, 5, 8, 3, 0, 1, 1);
    run(3, 5, 8, 3, 0, 1, 1);
    run(3, 5, 8, 3, 0, 1, 1);
    run(3, 5, 8, 3, 0, 1, 1);
    run(3, 5, 8, 3, 0, 1, 1);
    drain("drain_duty", 20);
    chk("locked_before_en_drop", int'(locked), 1);

    // en low for one cycle: lock lost, partial period discarded
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("locked_after_en_drop", int'(locked), 0);
    pend_v      = 1'b0;
    num_div_exp = 4'd4;
    @(negedge clk);
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 0);

    // Input stuck low: single timeout, partial period discarded
    pend_v = 1'b0;
    q.push_back('{1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0});
    drain("drain_timeout", 120);
    repeat (20) @(negedge clk);
    chk("locked_after_timeout", int'(locked), 0);

    // Recovery from WAIT_EDGE, then asynchronous reset mid-period
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 0);
    drain("drain_pre_reset", 20);
    clk_div_in = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_period", int'(period), 0);
    chk("arst_high_time", int'(high_time), 0);
    chk("arst_locked", int'(locked), 0);
    chk("arst_pulses", int'({meas_vld, err_mismatch, err_duty, timeout}), 0);
    pend_v = 1'b0;
    @(negedge clk);
    clk_div_in = 1'b0;
    rst_n      = 1'b1;
    repeat (2) @(negedge clk);
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 0);
    run(2, 2, 4, 2, 0, 0, 0);
    drain("drain_post_reset", 20);
    repeat (10) @(negedge clk);
    chk("queue_empty_end", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clk_div_meter.md
CLK_DIV_METER -- requirements
Module: clk_div_meter

Interface
REQ-001 Parameter WIDTH_NUM_DIV, default 4, is the width of the expected division ratio.
REQ-002 Parameter LOCK_CNT, default 3, is the number of consecutive equal periods required for lock (range 1..7).
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  measurement enable; low forces IDLE.
REQ-006 clk_div_in  input  1  divided clock under test, asynchronous to the meter.
REQ-007 num_div_exp  input  WIDTH_NUM_DIV  expected period in clk cycles (even, >=2).
REQ-008 period  output  WIDTH_NUM_DIV+2  last measured period in clk cycles.
REQ-009 high_time  output  WIDTH_NUM_DIV+2  last measured high-phase length in clk cycles.
REQ-010 meas_vld  output  1  one-cycle pulse when period/high_time update.
REQ-011 locked  output  1  level; LOCK_CNT consecutive equal periods seen.
REQ-012 err_mismatch  output  1  one-cycle pulse; measured period != num_div_exp.
REQ-013 err_duty  output  1  one-cycle pulse; high_time*2 != period.
REQ-014 timeout  output  1  one-cycle pulse; no rising edge within counter range.

Function
REQ-015 clk_div_in SHALL pass a 2-flop synchronizer, then a third flop for edge detect; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-016 States: IDLE, WAIT_EDGE, MEASURE; IDLE->WAIT_EDGE when en=1; any state->IDLE when en=0 (next cycle, counters cleared, locked cleared).
REQ-017 WAIT_EDGE: on rise, clear period counter to 1, go MEASURE; no outputs change.
REQ-018 MEASURE: period counter increments by 1 per clk; high counter increments while s2=1; fall latches high counter.
REQ-019 On rise in MEASURE: period <= counter value, high_time <= latched high count, meas_vld=1 the following cycle, counter reloads to 1 (no dead cycle between periods).
REQ-020 Measurement is exact: clk_div_in with period P clk cycles yields period=P, independent of synchronizer latency (2-cycle constant offset cancels).
REQ-021 err_mismatch SHALL pulse with meas_vld when period != zero-extended num_div_exp; err_duty SHALL pulse with meas_vld when {high_time,1'b0} != period.
REQ-022 Lock counter (3 bits): on meas_vld, if period equals previous period increment (saturate at LOCK_CNT) else reset to 1; locked=1 while counter==LOCK_CNT.
REQ-023 Any err_mismatch or timeout SHALL clear locked in the same cycle the pulse is asserted.
REQ-024 Period counter saturates at all-ones; reaching all-ones in MEASURE or WAIT_EDGE SHALL pulse timeout, clear locked and lock counter, and go WAIT_EDGE.
REQ-025 Rise coinciding with en falling: en wins, no meas_vld.
REQ-026 num_div_exp changing mid-measurement: compare uses value sampled at meas_vld cycle.

Reset
REQ-027 rst_n low asynchronously: state=IDLE, synchronizer flops=0, all counters=0, period=0, high_time=0, meas_vld=0, locked=0, err_mismatch=0, err_duty=0, timeout=0.
REQ-028 rst_n assertion mid-measurement discards the partial period; first meas_vld after release requires two rises of clk_div_in.

Verification
REQ-029 clk_div_in from an even divider with num_div=4, num_div_exp=4, en=1 -> period=4, high_time=2 every 4 cycles, no errors, locked=1 after 3rd meas_vld.
REQ-030 Divider switched from num_div=4 to 8 while locked -> one err_mismatch, locked=0, period=8 thereafter; with num_div_exp=8 relocks after 3 meas_vld.
REQ-031 clk_div_in held at 0 for 64 cycles (WIDTH_NUM_DIV=4) -> timeout pulse at saturation, locked=0, state WAIT_EDGE, no meas_vld.
REQ-032 clk_div_in high 3 cycles, low 5 cycles, num_div_exp=8 -> period=8, high_time=3, err_duty pulses each measurement, err_mismatch never.
REQ-033 rst_n pulsed low mid-period, then released -> all outputs 0 immediately; first meas_vld only after second rise of clk_div_in.
REQ-034 en dropped for 1 cycle while locked -> locked=0 next cycle; re-arm needs 2 rises before meas_vld.
